// File: rtl/cpu.sv
// cpu: single-cycle 16-bit MIPS16-subset processor with internal ROM/RAM.
// Ports: clk (rising-edge clock), rst (synchronous active-high reset).
module cpu #(
    parameter string IMEM_FILE = "imem.hex"
) (
    input logic clk,
    input logic rst
);

    logic [15:0] pc;
    logic [15:0] rf   [0:7];
    logic [15:0] imem [0:255];
    logic [15:0] dmem [0:255];

    initial begin : imem_init
        for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
        imem[0] = 16'h1045;
        imem[1] = 16'h1083;
        imem[2] = 16'h0298;
        imem[3] = 16'h30C0;
        imem[4] = 16'h2100;
    end

    logic [15:0] instr;
    logic [3:0]  op;
    logic [2:0]  rs_a;
    logic [2:0]  rt_a;
    logic [2:0]  rd_a;
    logic [2:0]  funct;
    logic [15:0] simm;
    logic [15:0] rs_v;
    logic [15:0] rt_v;
    logic [15:0] alu;
    logic [15:0] pc_inc;
    logic [7:0]  addr;

    logic [15:0] pc_d;
    logic [15:0] wd_d;
    logic [2:0]  wa_d;
    logic        we_d;
    logic        st_d;

    assign instr  = imem[pc[7:0]];
    assign op     = instr[15:12];
    assign rs_a   = instr[11:9];
    assign rt_a   = instr[8:6];
    assign rd_a   = instr[5:3];
    assign funct  = instr[2:0];
    assign simm   = {{10{instr[5]}}, instr[5:0]};
    assign rs_v   = (rs_a == 3'd0) ? 16'h0000 : rf[rs_a];
    assign rt_v   = (rt_a == 3'd0) ? 16'h0000 : rf[rt_a];
    assign addr   = rs_v[7:0] + simm[7:0];
    assign pc_inc = pc + 16'd1;

    always_comb begin
        alu = 16'h0000;
        case (funct)
            3'd0: alu = rs_v + rt_v;
            3'd1: alu = rs_v - rt_v;
            3'd2: alu = rs_v & rt_v;
            3'd3: alu = rs_v | rt_v;
            3'd4: alu = {15'd0, $signed(rs_v) < $signed(rt_v)};
            3'd5: alu = ~(rs_v | rt_v);
            default: alu = 16'h0000;
        endcase
    end

    always_comb begin
        pc_d = pc_inc;
        we_d = 1'b0;
        wa_d = rd_a;
        wd_d = alu;
        st_d = 1'b0;
        case (op)
            4'd0: we_d = (funct < 3'd6);
            4'd1: begin
                we_d = 1'b1;
                wa_d = rt_a;
                wd_d = rs_v + simm;
            end
            4'd2: begin
                we_d = 1'b1;
                wa_d = rt_a;
                wd_d = dmem[addr];
            end
            4'd3: st_d = 1'b1;
            4'd4: if (rs_v == rt_v) pc_d = pc_inc + simm;
            4'd5: if (rs_v != rt_v) pc_d = pc_inc + simm;
            4'd6: pc_d = {pc[15:12], instr[11:0]};
            default: pc_d = pc_inc;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= 16'h0000;
            for (int i = 0; i < 8; i++) rf[i] <= 16'h0000;
            for (int i = 0; i < 256; i++) dmem[i] <= 16'h0000;
        end else begin
            pc <= pc_d;
            if (we_d && (wa_d != 3'd0)) rf[wa_d] <= wd_d;
            if (st_d) dmem[addr] <= rt_v;
        end
    end

endmodule

// File: tb/tb_cpu.sv
// tb_cpu: checks cpu against an instruction-level model of the ISA.
// Ports: none (drives clk/rst of the cpu instance).
module tb_cpu;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;

    cpu dut (
        .clk(clk),
        .rst(rst)
    );

    always #5 clk = ~clk;

    logic [15:0] m_imem [0:255];
    logic [15:0] m_dmem [0:255];
    logic [15:0] m_rf   [0:7];
    logic [15:0] m_pc;

    task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] enc_r(int f, int s, int t, int d);
        return {4'd0, 3'(s), 3'(t), 3'(d), 3'(f)};
    endfunction

    function automatic logic [15:0] enc_i(int op, int s, int t, int imm);
        return {4'(op), 3'(s), 3'(t), 6'(imm)};
    endfunction

    function automatic logic [15:0] enc_j(int tgt);
        return {4'd6, 12'(tgt)};
    endfunction

    task automatic m_reset();
        m_pc = 16'h0000;
        for (int i = 0; i < 8; i++) m_rf[i] = 16'h0000;
        for (int i = 0; i < 256; i++) m_dmem[i] = 16'h0000;
    endtask

    // One instruction of the ISA, computed from register/memory contents.
    task automatic m_step();
        logic [15:0] ins, a, b, imm, res, nxt;
        int s, t, d, f;
        ins = m_imem[m_pc % 256];
        s = int'(ins[11:9]);
        t = int'(ins[8:6]);
        d = int'(ins[5:3]);
        f = int'(ins[2:0]);
        a = m_rf[s];
        b = m_rf[t];
        imm = 16'($signed(ins[5:0]));
        nxt = m_pc + 16'd1;
        case (int'(ins[15:12]))
            0: begin
                res = 16'h0000;
                case (f)
                    0: res = a + b;
                    1: res = a - b;
                    2: res = a & b;
                    3: res = a | b;
                    4: res = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
                    5: res = ~(a | b);
                    default: res = 16'h0000;
                endcase
                if (f < 6 && d != 0) m_rf[d] = res;
            end
            1: if (t != 0) m_rf[t] = a + imm;
            2: if (t != 0) m_rf[t] = m_dmem[(a + imm) % 256];
            3: m_dmem[(a + imm) % 256] = b;
            4: if (a == b) nxt = nxt + imm;
            5: if (a != b) nxt = nxt + imm;
            6: nxt = {m_pc[15:12], ins[11:0]};
            default: nxt = nxt;
        endcase
        m_pc = nxt;
    endtask

    task automatic cmp_state(string tag);
        chk({tag, " pc"}, dut.pc, m_pc);
        for (int r = 0; r < 8; r++)
            chk($sformatf("%s r%0d", tag, r), dut.rf[r], m_rf[r]);
    endtask

    task automatic cmp_dmem(string tag);
        for (int i = 0; i < 256; i++)
            chk($sformatf("%s dmem[%0d]", tag, i), dut.dmem[i], m_dmem[i]);
    endtask

    task automatic do_reset(string tag);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        m_reset();
        cmp_state(tag);
        cmp_dmem(tag);
    endtask

    task automatic run(int n, string tag);
        for (int k = 0; k < n; k++) begin
            @(posedge clk);
            #1;
            m_step();
            cmp_state($sformatf("%s s%0d", tag, k));
        end
    endtask

    task automatic load(input logic [15:0] p[$]);
        for (int i = 0; i < 256; i++) begin
            dut.imem[i] = 16'h0000;
            m_imem[i] = 16'h0000;
        end
        for (int i = 0; i < p.size(); i++) begin
            dut.imem[i] = p[i];
            m_imem[i] = p[i];
        end
    endtask

    logic [15:0] prog[$];

    initial begin
        for (int i = 0; i < 256; i++) m_imem[i] = 16'h0000;
        m_imem[0] = 16'h1045;
        m_imem[1] = 16'h1083;
        m_imem[2] = 16'h0298;
        m_imem[3] = 16'h30C0;
        m_imem[4] = 16'h2100;
        #1;
        for (int i = 0; i < 8; i++)
            chk($sformatf("rom[%0d]", i), dut.imem[i], m_imem[i]);

        do_reset("rst0");
        run(5, "dflt");
        chk("dflt r1", dut.rf[1], 16'd5);
        chk("dflt r2", dut.rf[2], 16'd3);
        chk("dflt r3", dut.rf[3], 16'd8);
        chk("dflt r4", dut.rf[4], 16'd8);
        chk("dflt pc", dut.pc, 16'd5);
        chk("dflt dmem0", dut.dmem[0], 16'd8);
        cmp_dmem("dflt");

        do_reset("rst1");
        run(3, "pre");
        do_reset("midrst");
        chk("midrst pc", dut.pc, 16'd0);
        chk("midrst r3", dut.rf[3], 16'd0);
        chk("midrst dmem0", dut.dmem[0], 16'd0);
        run(5, "rerun");
        chk("rerun r4", dut.rf[4], 16'd8);
        chk("rerun dmem0", dut.dmem[0], 16'd8);

        prog = '{enc_i(4, 0, 0, 2)};
        load(prog);
        do_reset("beq");
        run(1, "beq");
        chk("beq taken pc", dut.pc, 16'd3);

        prog = '{enc_i(5, 0, 0, 2)};
        load(prog);
        do_reset("bne");
        run(1, "bne");
        chk("bne fall pc", dut.pc, 16'd1);

        prog = '{16'h0, 16'h0, 16'h0, 16'h0, enc_i(4, 0, 0, -1)};
        load(prog);
        do_reset("loop");
        run(7, "loop");
        chk("self loop pc", dut.pc, 16'd4);

        prog = '{16'h0, 16'h0, 16'h0, 16'h0, 16'h0, enc_j(12'h0A0)};
        load(prog);
        dut.imem[8'hA0] = enc_i(1, 0, 1, 7);
        m_imem[8'hA0] = enc_i(1, 0, 1, 7);
        do_reset("jmp");
        run(6, "jmp");
        chk("jump pc", dut.pc, 16'h00A0);
        run(1, "jmp2");
        chk("jump fetch r1", dut.rf[1], 16'd7);

        prog = '{enc_i(1, 0, 1, -32), enc_i(1, 0, 2, 1),
                 enc_r(1, 0, 2, 3), enc_r(4, 3, 2, 4),
                 enc_i(1, 0, 0, 7), enc_r(4, 2, 3, 5),
                 enc_r(5, 0, 0, 6), enc_r(2, 1, 3, 7),
                 enc_r(6, 1, 1, 7), enc_r(3, 2, 1, 2)};
        load(prog);
        do_reset("alu");
        run(10, "alu");
        chk("addi neg", dut.rf[1], 16'hFFE0);
        chk("sub 0-1", dut.rf[3], 16'hFFFF);
        chk("slt neg", dut.rf[4], 16'd1);
        chk("r0 stays 0", dut.rf[0], 16'd0);
        chk("slt pos", dut.rf[5], 16'd0);
        chk("nor", dut.rf[6], 16'hFFFF);
        chk("and+nop", dut.rf[7], 16'hFFE0);
        chk("or", dut.rf[2], 16'hFFE1);

        prog = '{enc_i(1, 0, 1, 16), enc_r(0, 1, 1, 1),
                 enc_r(0, 1, 1, 1), enc_r(0, 1, 1, 1),
                 enc_r(0, 1, 1, 1), enc_r(0, 1, 0, 4),
                 enc_i(1, 1, 1, 5), enc_i(1, 0, 2, 9),
                 enc_i(3, 1, 2, 0), enc_r(1, 0, 4, 3),
                 enc_i(1, 3, 3, 5), enc_i(2, 3, 5, 0)};
        load(prog);
        do_reset("wrap");
        run(12, "wrap");
        chk("wrap r1", dut.rf[1], 16'h0105);
        chk("wrap r3", dut.rf[3], 16'hFF05);
        chk("wrap sw", dut.dmem[5], 16'd9);
        chk("wrap lw", dut.rf[5], 16'd9);
        cmp_dmem("wrap");

        for (int p = 0; p < 4; p++) begin
            prog.delete();
            for (int i = 0; i < 256; i++)
                prog.push_back(16'($urandom));
            load(prog);
            do_reset($sformatf("rnd%0d", p));
            run(300, $sformatf("rnd%0d", p));
            cmp_dmem($sformatf("rnd%0d", p));
        end

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
